// File: rtl/hps_ext_mbox_if.sv
// SET packet stream from the mailbox to the core-side device model.
// Handshake: a packet transfers on a rising clk_sys edge when set_valid && set_ready;
// set_valid and set_data hold until then, and set_ready may be asserted at any time.
interface hps_ext_mbox_if #(
  parameter int WORDS = 3
) ();
  logic [16*WORDS-1:0] set_data;
  logic                set_valid;
  logic                set_ready;

  modport master (output set_data, output set_valid, input set_ready);
  modport slave  (input set_data, input set_valid, output set_ready);
endinterface

// File: rtl/hps_ext_mbox.sv
// HPS<->core mailbox on EXT_BUS: GET returns status, snapshot request data or ready
// flags; SET packets are queued in a first-word-fall-through FIFO for the core.
module hps_ext_mbox #(
  parameter logic [15:0] CMD_GET    = 16'h34,
  parameter logic [15:0] CMD_SET    = 16'h35,
  parameter int          WORDS      = 3,
  parameter int          FIFO_DEPTH = 4,
  parameter int          NUM_RDY    = 2
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  inout  wire  [35:0]         EXT_BUS,
  input  logic [16*WORDS-1:0] req_data,
  input  logic                req_strobe,
  input  logic [NUM_RDY-1:0]  rdy_flags,
  hps_ext_mbox_if.master      set_if
);
  localparam int DW = 16 * WORDS;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0]   w_io_din;
  logic          w_io_strobe;
  logic          w_io_enable;
  logic          w_stb;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_status_rd;
  logic [15:0]   w_shadow_word;
  logic [63:0]   w_rdy_ext;

  logic          r_armed;
  logic          r_dout_en;
  logic [15:0]   r_io_dout;
  logic [9:0]    r_byte_cnt;
  logic [15:0]   r_cmd;
  logic [1:0]    r_sel;
  logic [5:0]    r_idx;
  logic          r_get_open;
  logic [7:0]    r_req_cnt;
  logic [DW-1:0] r_shadow;
  logic          r_pend;
  logic [DW-1:0] r_pend_data;
  logic          r_ovf;
  logic [DW-1:0] r_staging;
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;

  assign w_io_din    = EXT_BUS[31:16];
  assign w_io_strobe = EXT_BUS[33];
  assign w_io_enable = EXT_BUS[34];
  assign EXT_BUS[15:0] = r_io_dout;
  assign EXT_BUS[32]   = r_dout_en;

  assign w_stb       = w_io_enable && w_io_strobe && r_armed;
  assign w_status_rd = w_stb && (r_byte_cnt == 10'd0) && (w_io_din == CMD_GET);
  // Zero-extending to 64 bits makes any idx >= NUM_RDY read back as 0.
  assign w_rdy_ext   = 64'(rdy_flags);

  always_comb begin
    w_shadow_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_byte_cnt == 10'(k + 2)) w_shadow_word = r_shadow[16*k +: 16];
    end
  end

  assign w_empty    = (r_wp == r_rp);
  assign w_full     = ((r_wp ^ r_rp) == (AW+1)'(FIFO_DEPTH));
  assign w_pop      = !w_empty && set_if.set_ready;
  // byte_cnt is still nonzero on the first enable-low cycle, which is the falling edge.
  assign w_push_req = !w_io_enable && (r_cmd == CMD_SET) && (r_byte_cnt >= 10'(WORDS + 1));
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;

  assign set_if.set_valid = !w_empty;
  assign set_if.set_data  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_armed    <= 1'b0;
      r_dout_en  <= 1'b0;
      r_io_dout  <= '0;
      r_byte_cnt <= '0;
      r_cmd      <= '0;
      r_sel      <= '0;
      r_idx      <= '0;
      r_get_open <= 1'b0;
      r_staging  <= '0;
    end else if (!w_io_enable) begin
      r_armed    <= 1'b1;
      r_dout_en  <= 1'b0;
      r_io_dout  <= '0;
      r_byte_cnt <= '0;
      r_get_open <= 1'b0;
    end else if (w_stb) begin
      if (r_byte_cnt != 10'd1023) r_byte_cnt <= r_byte_cnt + 10'd1;
      r_io_dout <= '0;
      if (r_byte_cnt == 10'd0) begin
        r_cmd      <= w_io_din;
        r_dout_en  <= (w_io_din == CMD_GET) || (w_io_din == CMD_SET);
        r_get_open <= (w_io_din == CMD_GET);
        if (w_io_din == CMD_GET) r_io_dout <= {6'd0, r_ovf, w_full, r_req_cnt};
      end else if (r_cmd == CMD_GET) begin
        if (r_byte_cnt == 10'd1) begin
          r_sel <= w_io_din[1:0];
          r_idx <= w_io_din[7:2];
        end else if (r_sel == 2'd0) begin
          r_io_dout <= w_shadow_word;
        end else if ((r_sel == 2'd1) && (r_byte_cnt == 10'd2)) begin
          r_io_dout <= {15'd0, w_rdy_ext[r_idx]};
        end
      end else if (r_cmd == CMD_SET) begin
        for (int k = 0; k < WORDS; k++) begin
          if (r_byte_cnt == 10'(k + 1)) r_staging[16*k +: 16] <= w_io_din;
        end
      end
    end
  end

  // A request arriving during an open GET is parked so the HPS sees a consistent snapshot.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_req_cnt   <= '0;
      r_shadow    <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
    end else if (req_strobe) begin
      r_req_cnt <= r_req_cnt + 8'd1;
      if (!r_get_open) begin
        r_shadow <= req_data;
        r_pend   <= 1'b0;
      end else begin
        r_pend      <= 1'b1;
        r_pend_data <= req_data;
      end
    end else if (r_pend && !r_get_open) begin
      r_shadow <= r_pend_data;
      r_pend   <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (w_status_rd) r_ovf <= 1'b0;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= r_staging;
  end
endmodule

// File: tb/tb_hps_ext_mbox.sv
// Randomized bench for hps_ext_mbox: bus transactions are checked against a
// transaction-level model of status, snapshot data, ready flags and the SET queue.
module tb_hps_ext_mbox;
  localparam int WORDS = 3;
  localparam int DEPTH = 4;
  localparam int NRDY  = 2;
  localparam int DW    = 16 * WORDS;
  localparam logic [15:0] CMD_GET = 16'h34;
  localparam logic [15:0] CMD_SET = 16'h35;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  wire  [35:0]   ext_bus;
  logic [15:0]   tb_din = '0;
  logic          tb_strobe = 1'b0;
  logic          tb_enable = 1'b1;
  logic [DW-1:0] req_data = '0;
  logic          req_strobe = 1'b0;
  logic [NRDY-1:0] rdy_flags = '0;

  assign ext_bus[31:16] = tb_din;
  assign ext_bus[33]    = tb_strobe;
  assign ext_bus[34]    = tb_enable;

  hps_ext_mbox_if #(.WORDS(WORDS)) set_if ();

  hps_ext_mbox #(
    .CMD_GET(CMD_GET), .CMD_SET(CMD_SET), .WORDS(WORDS),
    .FIFO_DEPTH(DEPTH), .NUM_RDY(NRDY)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .EXT_BUS   (ext_bus),
    .req_data  (req_data),
    .req_strobe(req_strobe),
    .rdy_flags (rdy_flags),
    .set_if    (set_if)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // reference model
  logic [7:0]    m_req_cnt = '0;
  logic          m_ovf = 1'b0;
  logic [DW-1:0] m_shadow = '0;
  logic [DW-1:0] m_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tx_w[16];
  logic [15:0] rx_w[16];
  logic        rx_en[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    return {6'd0, m_ovf, (m_q.size() == DEPTH), m_req_cnt};
  endfunction

  function automatic logic [DW-1:0] rand_packet();
    logic [DW-1:0] p;
    for (int j = 0; j < WORDS; j++) p[16*j +: 16] = 16'($urandom_range(0, 65535));
    return p;
  endfunction

  // drivers
  task automatic run_xact(input int n, input bit pop_end, input int req_at, input logic [DW-1:0] req_d);
    @(negedge clk_sys); tb_enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      tb_din = tx_w[i];
      tb_strobe = 1'b1;
      if (i == req_at) begin
        req_data = req_d;
        req_strobe = 1'b1;
      end
      @(negedge clk_sys);
      tb_strobe = 1'b0;
      req_strobe = 1'b0;
      rx_w[i]  = ext_bus[15:0];
      rx_en[i] = ext_bus[32];
    end
    @(negedge clk_sys);
    tb_enable = 1'b0;
    if (pop_end) set_if.set_ready = 1'b1;
    @(negedge clk_sys);
    set_if.set_ready = 1'b0;
  endtask

  task automatic req_pulse(input logic [DW-1:0] d);
    @(negedge clk_sys);
    req_data = d;
    req_strobe = 1'b1;
    @(negedge clk_sys);
    req_strobe = 1'b0;
    m_req_cnt++;
    m_shadow = d;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, 64'(set_if.set_valid), 64'(m_q.size() > 0));
    check({tag, "_data"}, 64'(set_if.set_data), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
  endtask

  task automatic do_get(input int sel, input int idx, input int req_at);
    logic [1:0]    s;
    logic [5:0]    ix;
    logic [7:0]    hi;
    logic [15:0]   exp_status;
    logic [15:0]   e;
    logic [DW-1:0] rd;
    int            n;
    s  = 2'(sel);
    ix = 6'(idx);
    hi = 8'($urandom_range(0, 255));
    n  = WORDS + 3;
    tx_w[0] = CMD_GET;
    tx_w[1] = {hi, ix, s};
    for (int i = 2; i < n; i++) tx_w[i] = 16'($urandom_range(0, 65535));
    rd = rand_packet();
    exp_status = model_status();
    run_xact(n, 1'b0, req_at, rd);
    check("get_en", 64'(rx_en[0]), 64'd1);
    check("get_status", 64'(rx_w[0]), 64'(exp_status));
    check("get_w1", 64'(rx_w[1]), 64'd0);
    for (int k = 2; k < n; k++) begin
      e = '0;
      if (sel == 0 && (k - 2) < WORDS) e = m_shadow[16*(k-2) +: 16];
      else if (sel == 1 && k == 2)     e = (idx < NRDY) ? 16'(rdy_flags[idx]) : 16'd0;
      check($sformatf("get_s%0d_w%0d", sel, k), 64'(rx_w[k]), 64'(e));
    end
    m_ovf = 1'b0;
    if (req_at >= 0) begin
      m_req_cnt++;
      m_shadow = rd;
    end
  endtask

  task automatic do_set(input int nd, input bit pop_end);
    logic [DW-1:0] pkt;
    pkt = '0;
    tx_w[0] = CMD_SET;
    for (int i = 1; i <= nd; i++) begin
      tx_w[i] = 16'($urandom_range(0, 65535));
      if (i <= WORDS) pkt[16*(i-1) +: 16] = tx_w[i];
    end
    run_xact(nd + 1, pop_end, -1, '0);
    check("set_en", 64'(rx_en[0]), 64'd1);
    check("set_dout", 64'(rx_w[0]), 64'd0);
    if (pop_end && m_q.size() > 0) void'(m_q.pop_front());
    if (nd >= WORDS) begin
      if (m_q.size() < DEPTH) m_q.push_back(pkt);
      else                    m_ovf = 1'b1;
    end
    check_head("set_head");
  endtask

  task automatic pop_one();
    check_head("pop_pre");
    @(negedge clk_sys); set_if.set_ready = 1'b1;
    @(negedge clk_sys); set_if.set_ready = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
    check_head("pop_post");
  endtask

  // scoreboard-driven sequence
  initial begin
    set_if.set_ready = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst_dout", 64'(ext_bus[15:0]), 64'd0);
    check("rst_dout_en", 64'(ext_bus[32]), 64'd0);
    check("rst_valid", 64'(set_if.set_valid), 64'd0);
    check("rst_data", 64'(set_if.set_data), 64'd0);

    // transaction open at reset release is ignored
    @(negedge clk_sys); tb_din = CMD_GET; tb_strobe = 1'b1;
    @(negedge clk_sys); tb_strobe = 1'b0;
    check("unarmed_en", 64'(ext_bus[32]), 64'd0);
    check("unarmed_dout", 64'(ext_bus[15:0]), 64'd0);
    @(negedge clk_sys); tb_enable = 1'b0;
    @(negedge clk_sys);
    do_get(0, 0, -1);
    check("armed_status", 64'(rx_w[0]), 64'h0);

    repeat (3) req_pulse(48'h3333_2222_1111);
    do_get(0, 0, -1);
    check("req3_status", 64'(rx_w[0]), 64'h0003);
    check("req3_w2", 64'(rx_w[2]), 64'h1111);
    check("req3_w4", 64'(rx_w[4]), 64'h3333);

    // request inside an open GET is deferred
    do_get(0, 0, 2);
    check("defer_old", 64'(rx_w[3]), 64'h2222);
    do_get(0, 0, -1);

    rdy_flags = 2'b10;
    do_get(1, 1, -1);
    check("rdy_idx1", 64'(rx_w[2]), 64'd1);
    do_get(1, 5, -1);
    check("rdy_idx5", 64'(rx_w[2]), 64'd0);

    tx_w[1] = 16'hAAAA;
    run_xact(1, 1'b0, -1, '0);
    begin
      tx_w[0] = CMD_SET; tx_w[1] = 16'hAAAA; tx_w[2] = 16'hBBBB; tx_w[3] = 16'hCCCC;
      run_xact(4, 1'b0, -1, '0);
      m_q.push_back(48'hCCCC_BBBB_AAAA);
      check("set1_valid", 64'(set_if.set_valid), 64'd1);
      check("set1_data", 64'(set_if.set_data), 64'hCCCC_BBBB_AAAA);
    end
    do_set(2, 1'b0);
    check("short_no_push", 64'(set_if.set_data), 64'hCCCC_BBBB_AAAA);
    pop_one();

    repeat (5) do_set(WORDS, 1'b0);
    do_get(0, 0, -1);
    check("ovf_bit9", 64'(rx_w[0][9]), 64'd1);
    check("full_bit8", 64'(rx_w[0][8]), 64'd1);
    do_get(0, 0, -1);
    check("ovf_cleared", 64'(rx_w[0][9]), 64'd0);
    do_set(WORDS, 1'b1);
    do_get(0, 0, -1);
    check("pop_push_ovf", 64'(rx_w[0][9]), 64'd0);
    while (m_q.size() > 0) pop_one();

    // randomized phase
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: req_pulse(rand_packet());
        1: do_get($urandom_range(0, 3), $urandom_range(0, 7),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, WORDS + 2) : -1);
        2: do_set($urandom_range(WORDS - 1, WORDS + 2), 1'($urandom_range(0, 1)));
        3: if (m_q.size() > 0) pop_one(); else req_pulse(rand_packet());
        default: begin
          rdy_flags = NRDY'($urandom_range(0, 3));
          do_get(1, $urandom_range(0, 3), -1);
        end
      endcase
    end

    // request counter wrap
    while (m_req_cnt != 8'd255) req_pulse(rand_packet());
    do_get(0, 0, -1);
    check("cnt_255", 64'(rx_w[0][7:0]), 64'd255);
    req_pulse(rand_packet());
    do_get(0, 0, -1);
    check("cnt_wrap", 64'(rx_w[0][7:0]), 64'd0);

    while (m_q.size() > 0) pop_one();
    check("final_empty", 64'(set_if.set_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
